sum_window_accumulator: RTL and testbench

Downstream consumer of the 4-bit half-adder's `sum` output. It accepts one sum sample per valid/ready handshake and accumulates a fixed-size window of COUNT samples. It also tracks the largest sample in the window. At window end it presents the total and the maximum on a held valid/ready output port. It turns the adder's per-cycle results into per-window statistics for display or checking logic.

---
 rtl/sum_window_pkg.sv | 18 +
 rtl/sum_window_accumulator.sv | 100 ++++++++++
 tb/tb_sum_window_accumulator.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_window_pkg.sv
// Shared defaults, FSM state type and width helper for the sum window accumulator.
package sum_window_pkg;

  localparam int unsigned DEFAULT_DATA_W = 4;
  localparam int unsigned DEFAULT_COUNT  = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Smallest accumulator that cannot overflow for count samples of data_w bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned count);
    return data_w + $clog2(count);
  endfunction

endpackage

// File: rtl/sum_window_accumulator.sv
// Accumulates COUNT handshaked samples per window and presents the window total
// and maximum on a held valid/ready output port.
module sum_window_accumulator
  import sum_window_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned COUNT  = DEFAULT_COUNT,
  parameter int unsigned ACC_W  = acc_width(DATA_W, COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max
);

  localparam int unsigned CNT_W = $clog2(COUNT);

  if (COUNT < 2 || COUNT > 256) begin : g_bad_count
    $error("sum_window_accumulator: COUNT must be in 2..256");
  end
  if (ACC_W < acc_width(DATA_W, COUNT)) begin : g_bad_acc_w
    $error("sum_window_accumulator: ACC_W too narrow, totals could wrap");
  end

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [DATA_W-1:0]  max_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               last;
  logic [ACC_W-1:0]   sum_next;
  logic [DATA_W-1:0]  max_next;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);

  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == CNT_W'(COUNT - 1));
  assign sum_next = acc_q + ACC_W'(in_data);
  assign max_next = (in_data > max_q) ? in_data : max_q;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (accept && last) state_d = ST_HOLD;
        ST_HOLD:  if (out_ready)      state_d = ST_ACCUM;
        default:                      state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Window end folds the final sample straight into the outputs and restarts
  // the running statistics on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      out_sum <= '0;
      out_max <= '0;
    end else if (clr) begin
      acc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      out_sum <= '0;
      out_max <= '0;
    end else if (accept) begin
      if (last) begin
        out_sum <= sum_next;
        out_max <= max_next;
        acc_q   <= '0;
        max_q   <= '0;
        cnt_q   <= '0;
      end else begin
        acc_q   <= sum_next;
        max_q   <= max_next;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Self-checking bench for sum_window_accumulator: directed scenarios plus a
// randomized run checked against a queue-based window model.
module tb_sum_window_accumulator;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned COUNT  = 16;
  localparam int unsigned ACC_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open window, plus the held result.
  int m_win[$];
  bit m_hold = 1'b0;
  int m_sum  = 0;
  int m_max  = 0;

  sum_window_accumulator #(
    .DATA_W(DATA_W),
    .COUNT (COUNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_max  (out_max)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_win.delete();
    m_hold = 1'b0;
    m_sum  = 0;
    m_max  = 0;
  endtask

  // Drive one cycle (entered and left 1 time unit after a rising edge).
  task automatic step(input bit v, input int d, input bit r, input bit c);
    int s;
    int mx;
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = r;
    clr       = c;
    if (c) begin
      model_clear();
    end else if (!m_hold && v) begin
      m_win.push_back(d);
      if (m_win.size() == COUNT) begin
        s = 0;
        mx = 0;
        foreach (m_win[i]) begin
          s += m_win[i];
          if (m_win[i] > mx) mx = m_win[i];
        end
        m_sum  = s;
        m_max  = mx;
        m_hold = 1'b1;
        m_win.delete();
      end
    end else if (m_hold && r) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 4'd7;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_sum !== 8'd0 || out_max !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: out_sum=%0d out_max=%0d required 0/0", out_sum, out_max);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ramp_accum[%0d]: in_ready=%b out_valid=%b required 1/0", i, in_ready, out_valid);
      end
      step(1'b1, i, 1'b1, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'h78 || out_max !== 4'd15) begin
      errors++;
      $display("FAIL ramp_result: valid=%b ready=%b sum=%0d max=%0d required 1/0/120/15",
               out_valid, in_ready, out_sum, out_max);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ramp_pulse: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) step(1'b1, 15, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd240 || out_max !== 4'd15) begin
        errors++;
        $display("FAIL saturation[%0d]: valid=%b sum=%0d max=%0d required 1/240/15",
                 w, out_valid, out_sum, out_max);
      end
      step(1'b0, 0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) step(1'b1, 3, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'd48 || out_max !== 4'd3) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b sum=%0d max=%0d required 1/0/48/3",
                 k, out_valid, in_ready, out_sum, out_max);
      end
      step(1'b1, 9, 1'b0, 1'b0);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_sparse();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sparse_early[%0d]: out_valid=%b required 0", i, out_valid);
      end
      step((i % 2) == 0, 1, 1'b1, 1'b0);
      if (i == 30) break;
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd16 || out_max !== 4'd1) begin
      errors++;
      $display("FAIL sparse_result: valid=%b sum=%0d max=%0d required 1/16/1", out_valid, out_sum, out_max);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 7; i++) step(1'b1, 9, 1'b1, 1'b0);
    do_reset(2);
    for (int i = 0; i < 16; i++) step(1'b1, 2, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd32 || out_max !== 4'd2) begin
      errors++;
      $display("FAIL reset_mid_result: valid=%b sum=%0d max=%0d required 1/32/2", out_valid, out_sum, out_max);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_clr_hold();
    for (int i = 0; i < 16; i++) step(1'b1, 4, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd64) begin
      errors++;
      $display("FAIL clr_pre_hold: valid=%b sum=%0d required 1/64", out_valid, out_sum);
    end
    step(1'b1, 6, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_max !== 4'd0) begin
      errors++;
      $display("FAIL clr_hold: valid=%b sum=%0d max=%0d required 0/0/0", out_valid, out_sum, out_max);
    end
    // clr mid-window: partial samples and the clr-cycle sample are dropped.
    for (int i = 0; i < 5; i++) step(1'b1, 12, 1'b1, 1'b0);
    step(1'b1, 12, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 5, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd80 || out_max !== 4'd5) begin
      errors++;
      $display("FAIL clr_next_window: valid=%b sum=%0d max=%0d required 1/80/5", out_valid, out_sum, out_max);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int windows = 0;
    for (int n = 0; n < 1500; n++) begin
      checks++;
      if (in_ready !== !m_hold || out_valid !== m_hold) begin
        errors++;
        $display("FAIL random_flags[%0d]: in_ready=%b out_valid=%b required %b/%b",
                 n, in_ready, out_valid, !m_hold, m_hold);
      end
      if (m_hold) begin
        checks++;
        if (out_sum !== ACC_W'(m_sum) || out_max !== DATA_W'(m_max)) begin
          errors++;
          $display("FAIL random_result[%0d]: sum=%0d max=%0d required %0d/%0d",
                   n, out_sum, out_max, m_sum, m_max);
        end
        windows++;
      end
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 150) == 0);
    end
    checks++;
    if (windows == 0) begin
      errors++;
      $display("FAIL random_coverage: windows=%0d required >0", windows);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_sparse();
    test_reset_mid_window();
    test_clr_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
